// File: rtl/colision_vidas_if.sv
// Signal bundle between the screen/obstacle stages and the collision/lives block.
// The master side drives screen state, obstacle data and player mask; the slave
// side (colision_vidas) returns game status, lives, score, best score and the
// collision pulse.
interface colision_vidas_if;
    logic [3:0]  presente;
    logic        clk_ob;
    logic [20:0] disp_obs;
    logic [3:0]  obs_aleo;
    logic [6:0]  jugador;
    logic [1:0]  v_d;
    logic [2:0]  vidas;
    logic [15:0] puntaje;
    logic [15:0] record;
    logic        choque;

    modport master (
        output presente, clk_ob, disp_obs, obs_aleo, jugador,
        input  v_d, vidas, puntaje, record, choque
    );

    modport slave (
        input  presente, clk_ob, disp_obs, obs_aleo, jugador,
        output v_d, vidas, puntaje, record, choque
    );
endinterface

// File: rtl/colision_vidas.sv
// Collision, lives and score keeping for the obstacle game.
// Game events are evaluated once per obstacle step (a one-clk tick derived from
// clk_ob); leaving the game screen drops back to IDLE immediately.
module colision_vidas #(
    parameter logic [3:0] JUEGO     = 4'd3,
    parameter logic [2:0] VIDAS_INI = 3'd3,
    parameter logic [2:0] VIDAS_MAX = 3'd5,
    parameter logic [3:0] BONO      = 4'd11,
    parameter logic [1:0] T_INVUL   = 2'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    colision_vidas_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] HIT  = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    logic        s1_reg, s2_reg, s3_reg;
    logic        fill_reg, armed_reg;
    logic        tick;

    logic [1:0]  state_reg, state_next;
    logic [2:0]  vidas_reg, vidas_next;
    logic [15:0] puntaje_reg, puntaje_next;
    logic [15:0] record_reg, record_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        choque_reg, choque_next;

    logic        colision;
    logic [15:0] puntaje_inc;
    logic [15:0] puntaje_bcd;
    logic [4:0]  carry;
    logic        unused_bits;

    // Only the player column takes part in collision detection.
    assign unused_bits = ^bus.disp_obs[20:7];
    assign colision    = (bus.disp_obs[6:0] & bus.jugador) != 7'd0;

    // Edge detector on clk_ob. Until clk_ob has been seen low after reset, s2 and
    // s3 load the same value, so a clk_ob that is already high at reset release
    // cannot fake a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            s3_reg    <= 1'b0;
            fill_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            s1_reg    <= bus.clk_ob;
            s2_reg    <= s1_reg;
            s3_reg    <= armed_reg ? s2_reg : s1_reg;
            fill_reg  <= 1'b1;
            armed_reg <= armed_reg | (fill_reg & ~s1_reg);
        end
    end

    assign tick = s2_reg & ~s3_reg;

    // BCD increment with a per-digit carry chain.
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            logic [3:0] dig;
            assign dig            = puntaje_reg[4*gi +: 4];
            assign carry[gi+1]    = carry[gi] & (dig == 4'd9);
            assign puntaje_bcd[4*gi +: 4] = !carry[gi]    ? dig :
                                            (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        end
    endgenerate

    // Score stops at 9999 instead of wrapping to 0000.
    assign puntaje_inc = (puntaje_reg == 16'h9999) ? puntaje_reg : puntaje_bcd;

    // Next-state and datapath decisions; nothing but the screen-exit rule acts off-tick.
    always_comb begin
        state_next   = state_reg;
        vidas_next   = vidas_reg;
        puntaje_next = puntaje_reg;
        record_next  = record_reg;
        cnt_next     = cnt_reg;
        choque_next  = 1'b0;
        if (bus.presente != JUEGO) begin
            state_next = IDLE;
        end else if (tick) begin
            case (state_reg)
                IDLE: begin
                    state_next   = PLAY;
                    vidas_next   = VIDAS_INI;
                    puntaje_next = 16'h0000;
                    cnt_next     = 2'd0;
                end
                PLAY: begin
                    if (colision) begin
                        choque_next = 1'b1;
                        if (vidas_reg > 3'd1) begin
                            vidas_next = vidas_reg - 3'd1;
                            cnt_next   = 2'd0;
                            state_next = HIT;
                        end else begin
                            vidas_next = 3'd0;
                            state_next = OVER;
                            if (puntaje_reg > record_reg)
                                record_next = puntaje_reg;
                        end
                    end else begin
                        puntaje_next = puntaje_inc;
                        if (bus.obs_aleo == BONO && vidas_reg < VIDAS_MAX)
                            vidas_next = vidas_reg + 3'd1;
                    end
                end
                HIT: begin
                    // The T_INVUL-th tick spent in HIT hands control back to PLAY.
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == T_INVUL - 2'd1)
                        state_next = PLAY;
                end
                default: begin
                end
            endcase
        end
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            vidas_reg   <= 3'd0;
            puntaje_reg <= 16'h0000;
            record_reg  <= 16'h0000;
            cnt_reg     <= 2'd0;
            choque_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            vidas_reg   <= vidas_next;
            puntaje_reg <= puntaje_next;
            record_reg  <= record_next;
            cnt_reg     <= cnt_next;
            choque_reg  <= choque_next;
        end
    end

    // Status code for the obstacle stage.
    always_comb begin
        case (state_reg)
            HIT:     bus.v_d = 2'd1;
            OVER:    bus.v_d = 2'd2;
            default: bus.v_d = 2'd0;
        endcase
    end

    assign bus.vidas   = vidas_reg;
    assign bus.puntaje = puntaje_reg;
    assign bus.record  = record_reg;
    assign bus.choque  = choque_reg;

endmodule

// File: doc/colision_vidas.md
COLISION_VIDAS -- requirements
Module: colision_vidas

Interface
REQ-001 Parameter: JUEGO, 4'd3, value of presente meaning game screen active.
REQ-002 Parameter: VIDAS_INI, 3'd3, lives loaded at game start.
REQ-003 Parameter: VIDAS_MAX, 3'd5, lives saturation ceiling.
REQ-004 Parameter: BONO, 4'd11, obs_aleo code granting one extra life.
REQ-005 Parameter: T_INVUL, 2'd2, obstacle ticks of invulnerability after a hit.
REQ-006 Port: clk  in  1  27 MHz system clock; all flops on its rising edge.
REQ-007 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port: presente  in  4  top-level screen state.
REQ-009 Port: clk_ob  in  1  obstacle-stage step clock, a clk-derived level signal.
REQ-010 Port: disp_obs  in  21  obstacle columns; bits [6:0] are the player column.
REQ-011 Port: obs_aleo  in  4  current random/bonus code from the obstacle stage.
REQ-012 Port: jugador  in  7  player occupancy mask in the player column.
REQ-013 Port: v_d  out  2  game status to obstacle stage: 0 play/idle, 1 hit-clear, 2 game over.
REQ-014 Port: vidas  out  3  remaining lives.
REQ-015 Port: puntaje  out  16  score, 4 BCD digits, [15:12] most significant.
REQ-016 Port: record  out  16  best score, 4 BCD digits.
REQ-017 Port: choque  out  1  one-clk pulse on each registered collision.

Function
REQ-018 clk_ob SHALL pass through a 3-flop chain s1,s2,s3; tick = s2 & ~s3; all state and outputs SHALL update only on a clk edge where tick=1 (3rd clk edge after clk_ob rises), except the presente exit rule.
REQ-019 Collision SHALL be defined as (disp_obs[6:0] & jugador) != 0, sampled at tick.
REQ-020 FSM states: IDLE, PLAY, HIT, OVER; v_d = 0 in IDLE/PLAY, 1 in HIT, 2 in OVER.
REQ-021 IDLE->PLAY at the first tick with presente==JUEGO; on that edge vidas<=VIDAS_INI, puntaje<=0, invulnerability counter<=0; no collision, bonus or score evaluated on that tick.
REQ-022 From any state, presente!=JUEGO SHALL force IDLE on the next clk edge (tick not required); vidas, puntaje, record hold.
REQ-023 PLAY, tick, no collision: puntaje += 1 in BCD with per-digit carry, saturating at 9999; if obs_aleo==BONO additionally vidas += 1 saturating at VIDAS_MAX.
REQ-024 PLAY, tick, collision, vidas>1: vidas -= 1, choque pulses, counter<=0, ->HIT; bonus and score ignored that tick.
REQ-025 PLAY, tick, collision, vidas==1: vidas<=0, choque pulses, ->OVER; record<=puntaje if puntaje>record (BCD compare = unsigned binary compare of the 16-bit word).
REQ-026 HIT: each tick increments counter; collisions, bonus and score ignored; tick at which counter reaches T_INVUL-1 returns to PLAY.
REQ-027 OVER: all ticks ignored; stays until presente!=JUEGO.
REQ-028 choque SHALL be high for exactly one clk cycle, the cycle after the collision tick edge.
REQ-029 vidas SHALL never exceed VIDAS_MAX nor underflow below 0.

Reset
REQ-030 rst_n low SHALL asynchronously set state IDLE, s1..s3=0, vidas=0, puntaje=0, record=0, counter=0, choque=0, v_d=0.
REQ-031 Release of rst_n mid-game SHALL restart from IDLE; a clk_ob already high at release SHALL NOT produce a tick until it falls and rises again (s2 and s3 fill together from reset).

Verification
REQ-032 presente=3, 10 clk_ob pulses, disp_obs[6:0]=0 -> first tick enters PLAY, puntaje=0x0009, vidas=3, v_d=0.
REQ-033 PLAY vidas=3, disp_obs[6:0]=7'h08, jugador=7'h08 at tick -> vidas=2, choque one cycle, v_d=1 for 2 ticks, collisions at those ticks ignored, then v_d=0.
REQ-034 PLAY vidas=5, obs_aleo=11 no collision -> vidas stays 5, puntaje +1; vidas=4 -> 5; obs_aleo=11 with collision -> vidas=3.
REQ-035 puntaje=0x0099 tick -> 0x0100; puntaje=0x9999 tick -> stays 0x9999.
REQ-036 vidas=1, puntaje=0x0042, record=0x0030, collision -> vidas=0, v_d=2, record=0x0042; presente=0 -> IDLE next clk, v_d=0; re-entry -> vidas=3, puntaje=0, record=0x0042.
REQ-037 rst_n pulsed low in HIT with clk_ob high -> all outputs 0 immediately, no tick until next clk_ob rising edge.
